// File: rtl/ifu.sv
// Instruction fetch unit: issues one request at a time to instruction memory and holds each
// returned word for decode. Optional build macro IFU_MISALIGN_CHECK_EN: misaligned redirects fault.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_r, pc_nxt;
    logic [31:0] inst_r, inst_nxt;
    logic        discard, discard_nxt;
    logic        ferr, ferr_nxt;
    logic [31:0] redir_tgt;
    logic        redir_bad;

`ifdef IFU_MISALIGN_CHECK_EN
    assign redir_tgt = redirect_pc;
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^redirect_pc[1:0];
    assign redir_tgt = {redirect_pc[31:2], 2'b00};
    assign redir_bad = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_r;
        inst_nxt    = inst_r;
        discard_nxt = discard;
        ferr_nxt    = ferr;
        if (state == S_HALTED) begin
            state_nxt = S_HALTED;
        end else if (halt) begin
            // halt wins over everything, but a word consumed this cycle still retires
            state_nxt   = S_HALTED;
            discard_nxt = 1'b0;
            if (state == S_HOLD && inst_ready) pc_nxt = pc_r + 32'd4;
        end else if (redir_bad) begin
            state_nxt   = S_HALTED;
            ferr_nxt    = 1'b1;
            discard_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_REQ;
                    if (redirect_valid) pc_nxt = redir_tgt;
                end
                S_REQ: begin
                    if (redirect_valid) pc_nxt = redir_tgt;
                    if (imem_req_ready) begin
                        state_nxt   = S_WAIT;
                        discard_nxt = redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) pc_nxt = redir_tgt;
                    if (imem_rsp_valid) begin
                        // a response for a stale address is dropped and the new pc refetched
                        discard_nxt = 1'b0;
                        if (discard || redirect_valid) begin
                            state_nxt = S_REQ;
                        end else begin
                            inst_nxt  = imem_rsp_data;
                            state_nxt = S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        discard_nxt = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_nxt    = redir_tgt;
                        state_nxt = S_REQ;
                    end else if (inst_ready) begin
                        pc_nxt    = pc_r + 32'd4;
                        state_nxt = S_REQ;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc_r    <= RESET_PC;
            inst_r  <= 32'd0;
            discard <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_r    <= pc_nxt;
            inst_r  <= inst_nxt;
            discard <= discard_nxt;
            ferr    <= ferr_nxt;
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc_r;
    assign inst_valid     = (state == S_HOLD);
    assign inst           = inst_r;
    assign pc             = pc_r;
    assign fetch_err      = ferr;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus randomized traffic, all checked every cycle against
// a transaction-level model of the fetch unit.
module tb_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef IFU_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, inst_ready = 1'b0;
    logic        redirect_valid = 1'b0, halt = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0, redirect_pc = 32'd0;
    logic        imem_req_valid, inst_valid, fetch_err;
    logic [31:0] imem_req_addr, inst, pc;

    ifu #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .fetch_err(fetch_err)
    );

    int checks = 0;
    int errors = 0;

    // Model: what the unit is doing, as transaction facts rather than states.
    logic [31:0] m_pc = 32'd0, m_inst = 32'd0;
    bit m_start, m_pend, m_drop, m_held, m_halted, m_ferr;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp1("req_valid", imem_req_valid, !m_halted && !m_start && !m_pend && !m_held);
        cmp1("inst_valid", inst_valid, m_held);
        cmp("pc", pc, m_pc);
        cmp("req_addr", imem_req_addr, m_pc);
        if (m_held) cmp("inst", inst, m_inst);
        cmp1("fetch_err", fetch_err, m_ferr);
    endtask

    task automatic model_next();
        logic [31:0] tgt;
        tgt = MIS_EN ? redirect_pc : {redirect_pc[31:2], 2'b00};
        if (rst) begin
            m_pc = RESET_PC; m_start = 1; m_pend = 0; m_drop = 0;
            m_held = 0; m_halted = 0; m_ferr = 0;
        end else if (m_halted) begin
            m_halted = 1;
        end else if (halt) begin
            if (m_held && inst_ready) m_pc = m_pc + 32'd4;
            m_halted = 1; m_held = 0; m_pend = 0; m_start = 0; m_drop = 0;
        end else if (MIS_EN && redirect_valid && redirect_pc[1:0] != 2'b00) begin
            m_halted = 1; m_ferr = 1; m_held = 0; m_pend = 0; m_start = 0; m_drop = 0;
        end else if (m_start) begin
            m_start = 0;
            if (redirect_valid) m_pc = tgt;
        end else if (m_held) begin
            if (redirect_valid) begin
                m_pc = tgt; m_held = 0;
            end else if (inst_ready) begin
                m_pc = m_pc + 32'd4; m_held = 0;
            end
        end else if (m_pend) begin
            if (imem_rsp_valid) begin
                m_pend = 0;
                if (!m_drop && !redirect_valid) begin
                    m_held = 1; m_inst = imem_rsp_data;
                end
                m_drop = 0;
            end else if (redirect_valid) begin
                m_drop = 1;
            end
            if (redirect_valid) m_pc = tgt;
        end else begin
            if (imem_req_ready) begin
                m_pend = 1; m_drop = redirect_valid;
            end
            if (redirect_valid) m_pc = tgt;
        end
    endtask

    // Called just after a falling edge: drive, advance one clock, check at the next falling edge.
    task automatic step(input logic r, input logic rdy, input logic rspv, input logic [31:0] rspd,
                        input logic irdy, input logic rv, input logic [31:0] rpc, input logic h);
        rst = r; imem_req_ready = rdy; imem_rsp_valid = rspv; imem_rsp_data = rspd;
        inst_ready = irdy; redirect_valid = rv; redirect_pc = rpc; halt = h;
        model_next();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        cmp("rst_pc", pc, 32'h8000_0000);
        cmp("rst_inst", inst, 32'h0);
        cmp1("rst_req_valid", imem_req_valid, 1'b0);
        cmp1("rst_inst_valid", inst_valid, 1'b0);
        cmp1("rst_fetch_err", fetch_err, 1'b0);

        // response right after reset is ignored; IDLE moves on to requesting
        step(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cmp1("first_req_valid", imem_req_valid, 1'b1);
        cmp("first_addr", imem_req_addr, 32'h8000_0000);
        cmp1("no_stray_inst", inst_valid, 1'b0);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        cmp1("wait_no_inst", inst_valid, 1'b0);
        step(0, 1, 1, 32'h0010_0093, 0, 0, 0, 0);
        cmp1("first_inst_valid", inst_valid, 1'b1);
        cmp("first_inst", inst, 32'h0010_0093);
        cmp("first_pc", pc, 32'h8000_0000);

        for (int i = 0; i < 5; i++) step(0, 1, 1, 32'h1234_5678, 0, 0, 0, 0);
        cmp("stall_inst", inst, 32'h0010_0093);
        cmp("stall_pc", pc, 32'h8000_0000);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        cmp1("seq_req_valid", imem_req_valid, 1'b1);
        cmp("seq_addr", imem_req_addr, 32'h8000_0004);

        // redirect while waiting drops the pending response
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h8000_0100, 0);
        step(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0);
        cmp1("drop_inst_valid", inst_valid, 1'b0);
        cmp1("redir_req_valid", imem_req_valid, 1'b1);
        cmp("redir_addr", imem_req_addr, 32'h8000_0100);

        step(0, 0, 0, 0, 0, 1, 32'h8000_0102, 0);
`ifdef IFU_MISALIGN_CHECK_EN
        cmp1("misalign_err", fetch_err, 1'b1);
        cmp1("misalign_halted", imem_req_valid, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`else
        cmp("misalign_forced", imem_req_addr, 32'h8000_0100);
        cmp1("misalign_no_err", fetch_err, 1'b0);
`endif

        // pc wraps at the top of the address space
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        cmp("wrap_start", imem_req_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0013, 0, 0, 0, 0);
        cmp("wrap_inst", inst, 32'h0000_0013);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        cmp("wrap_addr", imem_req_addr, 32'h0000_0000);

        // halt while a request is stalled; nothing more until reset
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, $urandom, 1, 0, 0, 0);
            cmp1("halted_req", imem_req_valid, 1'b0);
            cmp1("halted_inst", inst_valid, 1'b0);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            bit r, rdy, rspv, irdy, rv, h;
            logic [31:0] rp;
            r    = ($urandom_range(199) == 0);
            h    = ($urandom_range(149) == 0);
            rdy  = ($urandom_range(1) == 1);
            rspv = ($urandom_range(9) < 4);
            irdy = ($urandom_range(1) == 1);
            rv   = ($urandom_range(9) == 0);
            rp   = $urandom;
            if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
            step(r, rdy, rspv, $urandom, irdy, rv, rp, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 imem_req_addr  output  32  fetch address; equals the pc output.
REQ-007 imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 inst_valid  output  1  held instruction offered to decode.
REQ-010 inst_ready  input  1  decode consumes the instruction this cycle.
REQ-011 inst  output  32  held instruction word.
REQ-012 pc  output  32  address of the current fetch/held instruction.
REQ-013 redirect_valid  input  1  branch/jump redirect request.
REQ-014 redirect_pc  input  32  redirect target.
REQ-015 halt  input  1  stop fetching (driven by decode's ebreak detection).
REQ-016 fetch_err  output  1  misaligned redirect flag (see Configuration).

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, HOLD, HALTED; imem_req_valid=1 only in REQ; inst_valid=1 only in HOLD.
REQ-018 IDLE->REQ unconditionally on the next edge.
REQ-019 REQ: on imem_req_valid&&imem_req_ready, go to WAIT; otherwise stay in REQ with address stable.
REQ-020 WAIT: imem_rsp_valid SHALL be sampled only in WAIT; on rsp, latch imem_rsp_data into inst and go to HOLD.
REQ-021 HOLD: inst and pc SHALL stay stable until inst_ready; on inst_ready, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0) and go to REQ.
REQ-022 Minimum latency: with ready=1 and rsp one cycle after accept, inst_valid rises 2 cycles after the REQ accept; throughput is 1 instruction per 3 cycles.
REQ-023 Redirect in REQ/HOLD: pc<=redirect_pc and go to REQ; any held instruction SHALL be dropped, even if inst_ready is high in the same cycle.
REQ-024 Redirect in WAIT: pc<=redirect_pc and set a discard flag; the next response SHALL be dropped and the FSM SHALL go to REQ.
REQ-025 Redirect coinciding with a REQ accept SHALL go to WAIT with the discard flag set.
REQ-026 Redirect in IDLE SHALL update pc; the FSM still goes to REQ.
REQ-027 halt SHALL have highest priority: from any state, next state is HALTED; a halt coinciding with inst_ready still advances pc by 4.
REQ-028 HALTED: no requests, inst_valid=0, responses ignored; only rst exits.

Reset
REQ-029 While rst=1 at an edge: state=IDLE, pc=RESET_PC, inst=0, discard=0, fetch_err=0.
REQ-030 While in reset state: imem_req_valid=0 and inst_valid=0.
REQ-031 Reset SHALL abort any in-flight fetch; a response arriving in the first cycle after reset SHALL be ignored.

Configuration
REQ-032 Macro IFU_MISALIGN_CHECK_EN defined: an accepted redirect with redirect_pc[1:0]!=0 SHALL set fetch_err=1 (sticky until rst) and go to HALTED.
REQ-033 Macro IFU_MISALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 2'b00, and fetch_err SHALL be tied to 0.

Verification
REQ-034 Reset, then ready=1, rsp 1 cycle after accept with data 32'h00100093 -> first imem_req_addr=32'h8000_0000; inst_valid with inst=32'h00100093, pc=32'h8000_0000.
REQ-035 inst_ready held low 5 cycles in HOLD -> inst/pc stable and no new request; after ready, next imem_req_addr=32'h8000_0004.
REQ-036 Redirect to 32'h8000_0100 while in WAIT -> the pending response is dropped (inst_valid stays 0), then a request at 32'h8000_0100 is issued.
REQ-037 halt asserted in REQ with imem_req_ready=0 -> HALTED; no request or inst_valid afterward until rst.
REQ-038 Redirect to 32'h8000_0102: with IFU_MISALIGN_CHECK_EN -> fetch_err=1 and HALTED; without it -> request at 32'h8000_0100.
